// File: rtl/fs_pkg.sv
// Shared types and helpers for the FAST corner-score pipeline.
// Holds the ring-pixel class encoding, the default parameter values,
// a constant-foldable clog2 and the score saturation helper.
package fs_pkg;

    localparam int unsigned DEF_PIX_W   = 8;
    localparam int unsigned DEF_N_RING  = 16;
    localparam int unsigned DEF_ADDR_W  = 15;
    localparam int unsigned DEF_SCORE_W = 8;
    localparam int unsigned DEF_CNT_W   = 16;

    typedef enum logic [1:0] {
        SIMILAR = 2'b00,
        DARK    = 2'b01,
        BRIGHT  = 2'b10
    } pixClass_t;

    // Ceiling log2, evaluated at elaboration time for widths.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned acc;
        result = 0;
        acc    = 1;
        while (acc < value) begin
            acc    = acc << 1;
            result = result + 1;
        end
        return result;
    endfunction

    // Width of a margin sum over a whole ring at the default parameters.
    localparam int unsigned SUM_W = DEF_PIX_W + clog2(DEF_N_RING);

    // Clamp value to the largest number representable in width bits (width < 32).
    function automatic logic [31:0] saturate(input logic [31:0] value, input int unsigned width);
        logic [31:0] maxVal;
        maxVal = (32'(1) << width) - 32'(1);
        return (value > maxVal) ? maxVal : value;
    endfunction

endpackage

// File: rtl/fs_pixel_class.sv
// Classifies one ring pixel against the reference pixel and threshold.
// Ports:
//   refPix   - reference (centre) pixel
//   ringPix  - ring pixel under test
//   thres    - brightness threshold
//   pixClass - SIMILAR / DARK / BRIGHT
//   margin   - |ringPix-refPix| - thres for classified pixels, else 0
module fs_pixel_class
    import fs_pkg::*;
#(
    parameter int unsigned PIX_W = DEF_PIX_W
) (
    input  logic [PIX_W-1:0] refPix,
    input  logic [PIX_W-1:0] ringPix,
    input  logic [PIX_W-1:0] thres,
    output logic [1:0]       pixClass,
    output logic [PIX_W-1:0] margin
);

    // One extra bit so overflow/underflow of the bounds is visible.
    logic [PIX_W:0] upper;
    logic [PIX_W:0] lower;

    assign upper = {1'b0, refPix} + {1'b0, thres};
    assign lower = {1'b0, refPix} - {1'b0, thres};

    // An out-of-range bound means that side of the classification is empty.
    always_comb begin
        pixClass = SIMILAR;
        margin   = '0;
        if (!upper[PIX_W] && (ringPix > upper[PIX_W-1:0])) begin
            pixClass = BRIGHT;
            margin   = ringPix - upper[PIX_W-1:0];
        end else if (!lower[PIX_W] && (ringPix < lower[PIX_W-1:0])) begin
            pixClass = DARK;
            margin   = lower[PIX_W-1:0] - ringPix;
        end
    end

endmodule

// File: rtl/fs_score_pipe.sv
// Pipelined FAST corner-score unit: classify ring pixels (S1), form half-ring
// bright/dark margin sums (S2), pick and saturate the final score (S3) and
// issue the score-SRAM write. Valid/ready handshake with whole-pipe stall.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   in_valid / in_ready   - candidate beat handshake (in_ready combinational)
//   in_corner, in_addr    - corner flag and reference pixel address
//   in_ref, in_ring       - reference pixel, ring pixels (pixel 0 in MSBs)
//   thres                 - threshold, captured with the beat
//   out_valid / out_ready - result beat handshake (out_ready is the SRAM grant)
//   wren, waddr, wdata    - score-SRAM write port (wren combinational)
//   cnt_clear, corner_cnt - frame-start clear and saturating corner counter
module fs_score_pipe
    import fs_pkg::*;
#(
    parameter int unsigned PIX_W   = DEF_PIX_W,
    parameter int unsigned N_RING  = DEF_N_RING,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned SCORE_W = DEF_SCORE_W,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_corner,
    input  logic [ADDR_W-1:0]       in_addr,
    input  logic [PIX_W-1:0]        in_ref,
    input  logic [N_RING*PIX_W-1:0] in_ring,
    input  logic [PIX_W-1:0]        thres,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    wren,
    output logic [ADDR_W-1:0]       waddr,
    output logic [SCORE_W-1:0]      wdata,
    input  logic                    cnt_clear,
    output logic [CNT_W-1:0]        corner_cnt
);

    localparam int unsigned SUM_BITS = PIX_W + clog2(N_RING);
    localparam int unsigned HALF     = N_RING / 2;

    logic stall;

    // S1 combinational classification
    logic [PIX_W-1:0] ringPix [N_RING];
    logic [1:0]       classC  [N_RING];
    logic [PIX_W-1:0] marginC [N_RING];

    // S1 registers
    logic              s1Valid;
    logic              s1Corner;
    logic [ADDR_W-1:0] s1Addr;
    logic [1:0]        s1Class  [N_RING];
    logic [PIX_W-1:0]  s1Margin [N_RING];

    // S2 combinational / registers
    logic [SUM_BITS-1:0] brightLo, brightHi, darkLo, darkHi;
    logic                s2Valid;
    logic                s2Corner;
    logic [ADDR_W-1:0]   s2Addr;
    logic [SUM_BITS-1:0] s2BrightLo, s2BrightHi, s2DarkLo, s2DarkHi;

    // S3 combinational
    logic [SUM_BITS-1:0] sumBright, sumDark, best;
    logic [SCORE_W-1:0]  scoreC;
    logic                outCorner;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign wren     = out_valid & outCorner & out_ready;

    // One classifier per ring pixel; pixel 0 sits in the top bits.
    for (genvar i = 0; i < N_RING; i++) begin : gPix
        assign ringPix[i] = in_ring[(N_RING-1-i)*PIX_W +: PIX_W];
        fs_pixel_class #(.PIX_W(PIX_W)) uPixClass (
            .refPix   (in_ref),
            .ringPix  (ringPix[i]),
            .thres    (thres),
            .pixClass (classC[i]),
            .margin   (marginC[i])
        );
    end

    // Half-ring sums; class bits steer each margin to the bright or dark total.
    always_comb begin
        brightLo = '0;
        brightHi = '0;
        darkLo   = '0;
        darkHi   = '0;
        for (int i = 0; i < HALF; i++) begin
            if (s1Class[i] == BRIGHT) brightLo = brightLo + SUM_BITS'(s1Margin[i]);
            if (s1Class[i] == DARK)   darkLo   = darkLo   + SUM_BITS'(s1Margin[i]);
            if (s1Class[i+HALF] == BRIGHT) brightHi = brightHi + SUM_BITS'(s1Margin[i+HALF]);
            if (s1Class[i+HALF] == DARK)   darkHi   = darkHi   + SUM_BITS'(s1Margin[i+HALF]);
        end
    end

    // Final score: larger of the two totals, bright wins a tie.
    always_comb begin
        sumBright = s2BrightLo + s2BrightHi;
        sumDark   = s2DarkLo + s2DarkHi;
        best      = (sumBright >= sumDark) ? sumBright : sumDark;
        scoreC    = SCORE_W'(saturate(32'(best), SCORE_W));
    end

    // Pipeline registers; every stage holds while the output is stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1Valid   <= 1'b0;
            s2Valid   <= 1'b0;
            out_valid <= 1'b0;
            outCorner <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
        end else if (!stall) begin
            s1Valid    <= in_valid;
            s1Corner   <= in_corner;
            s1Addr     <= in_addr;
            s1Class    <= classC;
            s1Margin   <= marginC;

            s2Valid    <= s1Valid;
            s2Corner   <= s1Corner;
            s2Addr     <= s1Addr;
            s2BrightLo <= brightLo;
            s2BrightHi <= brightHi;
            s2DarkLo   <= darkLo;
            s2DarkHi   <= darkHi;

            out_valid  <= s2Valid;
            outCorner  <= s2Corner;
            waddr      <= s2Addr;
            wdata      <= scoreC;
        end
    end

    // Corner counter: clear beats a coincident write, saturates at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clear) begin
            corner_cnt <= '0;
        end else if (wren && (corner_cnt != '1)) begin
            corner_cnt <= corner_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/fs_score_pipe.md
Name: fs_score_pipe

Overview:
- Parametrised, pipelined FAST corner-score unit for the FAST9 accelerator. Sits between the corner detector and the score SRAM.
- Computes the bright/dark classification of each ring pixel internally, so no pre-computed compare vector is needed.
- Sums per-pixel margins, saturates the score and issues the score-SRAM write.
- Adds a valid/ready handshake with back-pressure and a per-frame corner counter.

Parameters:
- PIX_W, 8, pixel and threshold width
- N_RING, 16, ring pixels per candidate (power of 2, ≥4)
- ADDR_W, 15, score-SRAM address width
- SCORE_W, 8, stored score width
- CNT_W, 16, corner counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  candidate beat valid
- in_ready  out  1  unit can accept a beat
- in_corner  in  1  candidate passed the corner test
- in_addr  in  ADDR_W  reference pixel address
- in_ref  in  PIX_W  reference pixel
- in_ring  in  N_RING*PIX_W  ring pixels; pixel 0 in the MSBs
- thres  in  PIX_W  threshold, sampled with the beat
- out_valid  out  1  result beat valid
- out_ready  in  1  SRAM port grant
- wren  out  1  score-SRAM write enable
- waddr  out  ADDR_W  write address
- wdata  out  SCORE_W  score
- cnt_clear  in  1  clear the corner counter (frame start)
- corner_cnt  out  CNT_W  corners written since the last clear

Behaviour:
- Reset is synchronous: while rst_n=0 at a clk edge, all stage valids clear and corner_cnt goes to 0. Registered outputs reset as out_valid=0, waddr=0, wdata=0; wren=0 follows from out_valid=0. In-flight beats are dropped. Inputs are ignored in the reset cycle.
- Stall condition: stall = out_valid & ~out_ready. in_ready = ~stall (combinational).
- Beat movement: a beat is accepted when in_valid & in_ready. When stall=1, all stages hold.
- Latency: 3 cycles from acceptance to out_valid with no stall. One beat per cycle throughput. Order is preserved.
- S1 (classify), using PIX_W+1-bit arithmetic:
  - bright_i if ring_i > ref+thres; dark_i if ring_i < ref-thres.
  - If ref+thres overflows PIX_W there are no bright pixels; if ref-thres underflows there are no dark pixels.
  - Margin m_i = |ring_i-ref| - thres for classified pixels, otherwise 0.
  - Register margins, class bits, addr and corner flag.
- S2 (partial sums): register the bright and dark sums of each half ring, width PIX_W+log2(N_RING).
- S3 (final score):
  - sB = bright total, sD = dark total; s = max(sB, sD); tie selects sB.
  - wdata = s saturated to 2^SCORE_W-1.
  - Register wdata, waddr, corner flag and out_valid.
- Write enable: wren = out_valid & out_corner & out_ready (combinational). Non-corner beats still flow and drain through the handshake but never write.
- Counter:
  - corner_cnt increments on each wren and saturates at all-ones.
  - cnt_clear sets it to 0. If clear and wren coincide, clear wins and the result is 0.
- thres is captured per beat; changing it mid-stream affects only later beats.

Decomposition:
- Package fs_pkg:
  - class encoding SIMILAR=2'b00, DARK=2'b01, BRIGHT=2'b10
  - function clog2
  - sum width SUM_W = PIX_W+clog2(N_RING)
  - saturate function
- Sub-module fs_pixel_class: one ring pixel. Inputs ref, ring, thres; outputs class and PIX_W margin; instantiated N_RING times in S1.

Test Plan:
- ref=100, thres=10, ring 0..8 = 130, rest = 100, corner=1, addr=0x1234 → 3 cycles later wren=1, waddr=0x1234, wdata=180; corner_cnt=1.
- ref=100, thres=20, all ring = 200 → raw 1280 → wdata=255 (saturated, SCORE_W=8).
- ref=50, thres=10, ring 0..3 = 20, rest = 50 → dark total 80, wdata=80. ref=250, thres=10, all ring = 255 → wdata=0 (bright overflow guard).
- Stream 5 beats with out_ready=0 for cycles 3..7 → in_ready low while stalled, outputs held stable, all 5 written in order, none lost or duplicated. A non-corner beat passes with wren=0 and the counter is unchanged.
- corner_cnt=7, cnt_clear asserted in the same cycle as a wren → corner_cnt=0. Force the counter to all-ones, then write → stays all-ones.
- Assert rst_n=0 for one cycle with 2 beats in flight → out_valid=0 next cycle, no wren, corner_cnt=0, in_ready=1.
